// File: rtl/ram_pkg.sv
// Shared definitions for the data RAM with MOV/MOC handshake.
// Holds the typeData encodings, read/write constants, FSM state encoding and
// the address alignment helpers. Imported by data_ram_moc and ram_lane_ctl.
package ram_pkg;

  // typeData encodings; 2'b11 is an alias for a word access.
  localparam logic [1:0] TD_BYTE     = 2'b00;
  localparam logic [1:0] TD_HALF     = 2'b01;
  localparam logic [1:0] TD_WORD     = 2'b10;
  localparam logic [1:0] TD_WORD_ALT = 2'b11;

  // RW encodings.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Low two address bits with the alignment forced by the access size.
  function automatic logic [1:0] align_lo(input logic [1:0] td, input logic [1:0] lo);
    logic [1:0] res;
    res = lo;
    if (td == TD_HALF) begin
      res[0] = 1'b0;
    end else if (td[1]) begin
      res = 2'b00;
    end
    return res;
  endfunction

  // True when the low address bits do not suit the access size.
  function automatic logic is_misaligned(input logic [1:0] td, input logic [1:0] lo);
    return align_lo(td, lo) != lo;
  endfunction

endpackage

// File: rtl/ram_lane_ctl.sv
// Big-endian byte lane control for the data RAM (purely combinational).
// Lane k is the byte at (aligned address + k); lane 0 is the most significant
// byte of a word and sits in bits [31:24] of the packed lane buses.
// Ports:
//   type_data  in   2  access size (byte / halfword / word)
//   wdata      in  32  right-justified write data
//   rbytes     in  32  bytes read from lanes 0..3, lane 0 in [31:24]
//   byte_en    out  4  byte_en[k] enables lane k
//   wlanes     out 32  write bytes placed on their lanes, lane 0 in [31:24]
//   rdata      out 32  read data merged and zero-extended
module ram_lane_ctl
  import ram_pkg::*;
(
  input  logic [1:0]  type_data,
  input  logic [31:0] wdata,
  input  logic [31:0] rbytes,
  output logic [3:0]  byte_en,
  output logic [31:0] wlanes,
  output logic [31:0] rdata
);

  always_comb begin
    byte_en = 4'b1111;
    wlanes  = wdata;
    rdata   = rbytes;
    unique case (type_data)
      TD_BYTE: begin
        byte_en = 4'b0001;
        wlanes  = {wdata[7:0], 24'h0};
        rdata   = {24'h0, rbytes[31:24]};
      end
      TD_HALF: begin
        byte_en = 4'b0011;
        wlanes  = {wdata[15:0], 16'h0};
        rdata   = {16'h0, rbytes[31:16]};
      end
      TD_WORD, TD_WORD_ALT: begin
        byte_en = 4'b1111;
        wlanes  = wdata;
        rdata   = rbytes;
      end
      default: begin
        byte_en = 4'b1111;
        wlanes  = wdata;
        rdata   = rbytes;
      end
    endcase
  end

endmodule

// File: rtl/data_ram_moc.sv
// Byte-addressable big-endian data/instruction RAM with a MOV/MOC handshake
// and a fixed access latency, so the control unit sees real wait states.
// Optional macro MISALIGN_ERR_EN: adds ERR and rejects misaligned halfword or
// word accesses instead of force-aligning them.
// Ports:
//   CLK       in   1       system clock, rising edge
//   CLR       in   1       asynchronous active-low reset
//   MOV       in   1       memory operation valid, held until MOC is seen
//   RW        in   1       1 = read, 0 = write
//   typeData  in   2       00 byte, 01 halfword, 10/11 word
//   address   in   ADDR_W  byte address
//   DataIn    in  32       right-justified write data
//   DataOut   out 32       registered, zero-extended read data
//   MOC       out  1       memory operation complete
//   ERR       out  1       misaligned access flag (MISALIGN_ERR_EN only)
module data_ram_moc
  import ram_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        typeData,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC
`ifdef MISALIGN_ERR_EN
  ,
  output logic              ERR
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q;
  logic [1:0]        td_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       dout_q, dout_d;
  logic              capture;
  logic              access;
  logic              mis;
  logic [ADDR_W-1:0] addr_al;

  logic [7:0]        mem [Depth];

  logic [ADDR_W-1:0] lane_addr [4];
  logic [31:0]       rbytes;
  logic [3:0]        byte_en;
  logic [31:0]       wlanes;
  logic [31:0]       rdata;
  logic              we;

`ifdef MISALIGN_ERR_EN
  logic mis_q;
  assign mis = mis_q;
  assign ERR = (state_q == S_DONE) && mis_q;
`else
  assign mis = 1'b0;
`endif

  // Force-align the incoming address so an access never wraps past the top.
  always_comb begin
    addr_al       = address;
    addr_al[1:0]  = align_lo(typeData, address[1:0]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MOV) begin
          capture = 1'b1;
          cnt_d   = LatM1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        // MOV must be seen low before a new request is accepted.
        if (!MOV) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= RW_READ;
      td_q    <= TD_BYTE;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        rw_q    <= RW;
        td_q    <= typeData;
        addr_q  <= addr_al;
        wdata_q <= DataIn;
      end
    end
  end

`ifdef MISALIGN_ERR_EN
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      mis_q <= 1'b0;
    end else if (capture) begin
      mis_q <= is_misaligned(typeData, address[1:0]);
    end
  end
`endif

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = addr_q + ADDR_W'(k);
    end
    rbytes = {mem[lane_addr[0]], mem[lane_addr[1]], mem[lane_addr[2]], mem[lane_addr[3]]};
  end

  ram_lane_ctl u_lane_ctl (
    .type_data (td_q),
    .wdata     (wdata_q),
    .rbytes    (rbytes),
    .byte_en   (byte_en),
    .wlanes    (wlanes),
    .rdata     (rdata)
  );

  // Writes commit on the BUSY->DONE edge; a reset in BUSY never gets here.
  assign we = access && (rw_q == RW_WRITE) && !mis;

  always_ff @(posedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      if (we && byte_en[k]) begin
        mem[lane_addr[k]] <= wlanes[31-8*k -: 8];
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (access && (rw_q == RW_READ)) begin
      dout_d = mis ? 32'h0 : rdata;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      dout_q <= 32'h0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign DataOut = dout_q;
  assign MOC     = (state_q == S_DONE);

endmodule

// File: tb/tb_data_ram_moc.sv
// Directed bench for data_ram_moc: one instance at LATENCY=2 and one at
// LATENCY=1, both ADDR_W=8, expected values computed by hand.
module tb_data_ram_moc;
  import ram_pkg::*;

  logic        CLK;
  logic        CLR;
  logic        MOV, RW;
  logic [1:0]  typeData;
  logic [7:0]  address;
  logic [31:0] DataIn, DataOut;
  logic        MOC, ERR;

  logic        mov1, rw1;
  logic [1:0]  td1;
  logic [7:0]  addr1;
  logic [31:0] din1, dout1;
  logic        moc1, err1;

  int n_tests = 0;
  int n_fail  = 0;

  data_ram_moc #(.LATENCY(2), .ADDR_W(8)) u_dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .MOV      (MOV),
    .RW       (RW),
    .typeData (typeData),
    .address  (address),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .MOC      (MOC)
`ifdef MISALIGN_ERR_EN
    ,
    .ERR      (ERR)
`endif
  );

  data_ram_moc #(.LATENCY(1), .ADDR_W(8)) u_dut1 (
    .CLK      (CLK),
    .CLR      (CLR),
    .MOV      (mov1),
    .RW       (rw1),
    .typeData (td1),
    .address  (addr1),
    .DataIn   (din1),
    .DataOut  (dout1),
    .MOC      (moc1)
`ifdef MISALIGN_ERR_EN
    ,
    .ERR      (err1)
`endif
  );

`ifndef MISALIGN_ERR_EN
  assign ERR  = 1'b0;
  assign err1 = 1'b0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One handshake on the LATENCY=2 instance; request inputs are scrambled
  // after the accepting edge to show they are not used any more.
  task automatic access(input string tag, input logic rw, input logic [1:0] td,
                        input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] q, output logic e);
    int lat;
    @(posedge CLK); #1;
    MOV = 1'b1; RW = rw; typeData = td; address = a; DataIn = d;
    @(posedge CLK); #1;
    address = ~a; DataIn = ~d; RW = ~rw;
    lat = 1;
    while (!MOC && lat < 20) begin
      @(posedge CLK); #1;
      if (!MOC) lat++;
      else break;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd2);
    q = DataOut;
    e = ERR;
    MOV = 1'b0;
    @(posedge CLK); #1;
    check_eq({tag, "_moc_drop"}, {31'h0, MOC}, 32'h0);
  endtask

  logic [31:0] q;
  logic        e;
  int          lat;

  initial begin
    CLR = 1'b0; MOV = 1'b0; RW = 1'b1; typeData = TD_WORD; address = 8'h0; DataIn = 32'h0;
    mov1 = 1'b0; rw1 = 1'b1; td1 = TD_WORD; addr1 = 8'h0; din1 = 32'h0;
    #1;
    check_eq("rst_moc", {31'h0, MOC}, 32'h0);
    check_eq("rst_dout", DataOut, 32'h0);
    repeat (2) @(posedge CLK);
    #1 CLR = 1'b1;

    // Word write then read back.
    access("wr_word", 1'b0, TD_WORD, 8'h10, 32'hDEADBEEF, q, e);
    check_eq("wr_word_dout", q, 32'h0);
    access("rd_word", 1'b1, TD_WORD, 8'h10, 32'h0, q, e);
    check_eq("rd_word_dout", q, 32'hDEADBEEF);

    // Byte lanes.
    access("rd_byte", 1'b1, TD_BYTE, 8'h11, 32'h0, q, e);
    check_eq("rd_byte_dout", q, 32'h000000AD);
    access("wr_byte", 1'b0, TD_BYTE, 8'h12, 32'hFFFFFF55, q, e);
    check_eq("wr_keeps_dout", q, 32'h000000AD);
    access("rd_word2", 1'b1, TD_WORD, 8'h10, 32'h0, q, e);
    check_eq("rd_word2_dout", q, 32'hDEAD55EF);

    // Halfword at an odd address.
    access("rd_half_odd", 1'b1, TD_HALF, 8'h13, 32'h0, q, e);
`ifdef MISALIGN_ERR_EN
    check_eq("rd_half_odd_dout", q, 32'h0);
    check_eq("rd_half_odd_err", {31'h0, e}, 32'h1);
`else
    check_eq("rd_half_odd_dout", q, 32'h000055EF);
    check_eq("rd_half_odd_err", {31'h0, e}, 32'h0);
`endif

    // Halfword write, then a word read at a misaligned address.
    access("wr_half", 1'b0, TD_HALF, 8'h12, 32'hFFFFA1B2, q, e);
    access("rd_word_mis", 1'b1, TD_WORD_ALT, 8'h11, 32'h0, q, e);
`ifdef MISALIGN_ERR_EN
    check_eq("rd_word_mis_dout", q, 32'h0);
`else
    check_eq("rd_word_mis_dout", q, 32'hDEADA1B2);
`endif
    access("rd_half_al", 1'b1, TD_HALF, 8'h10, 32'h0, q, e);
    check_eq("rd_half_al_dout", q, 32'h0000DEAD);
    check_eq("rd_half_al_err", {31'h0, e}, 32'h0);

    // MOV held high after MOC: no re-trigger.
    @(posedge CLK); #1;
    MOV = 1'b1; RW = 1'b1; typeData = TD_BYTE; address = 8'h13;
    @(posedge CLK); #1;
    lat = 0;
    do begin
      @(posedge CLK); #1; lat++;
    end while (!MOC && lat < 20);
    check_eq("hold_lat", 32'(lat), 32'd2);
    check_eq("hold_dout", DataOut, 32'h000000B2);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check_eq("hold_moc", {31'h0, MOC}, 32'h1);
    end
    MOV = 1'b0;
    @(posedge CLK); #1;
    check_eq("hold_release", {31'h0, MOC}, 32'h0);
    access("after_hold", 1'b1, TD_BYTE, 8'h10, 32'h0, q, e);
    check_eq("after_hold_dout", q, 32'h000000DE);

    // Reset in BUSY aborts a write.
    access("wr_prior", 1'b0, TD_WORD, 8'h20, 32'hCAFEF00D, q, e);
    @(posedge CLK); #1;
    MOV = 1'b1; RW = 1'b0; typeData = TD_WORD; address = 8'h20; DataIn = 32'h12345678;
    @(posedge CLK); #1;
    CLR = 1'b0;
    #1;
    check_eq("rst_busy_moc", {31'h0, MOC}, 32'h0);
    check_eq("rst_busy_dout", DataOut, 32'h0);
    MOV = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_busy_moc2", {31'h0, MOC}, 32'h0);
    CLR = 1'b1;
    access("rd_after_rst", 1'b1, TD_WORD, 8'h20, 32'h0, q, e);
    check_eq("rd_after_rst_dout", q, 32'hCAFEF00D);

    // LATENCY=1 instance: write with MOV held, then read with MOV dropped in BUSY.
    @(posedge CLK); #1;
    mov1 = 1'b1; rw1 = 1'b0; td1 = TD_WORD; addr1 = 8'h40; din1 = 32'h0BADCAFE;
    @(posedge CLK); #1;
    check_eq("l1_wr_busy", {31'h0, moc1}, 32'h0);
    @(posedge CLK); #1;
    check_eq("l1_wr_moc", {31'h0, moc1}, 32'h1);
    mov1 = 1'b0;
    @(posedge CLK); #1;
    check_eq("l1_wr_drop", {31'h0, moc1}, 32'h0);
    mov1 = 1'b1; rw1 = 1'b1; td1 = TD_WORD; addr1 = 8'h40;
    @(posedge CLK); #1;
    mov1 = 1'b0;
    check_eq("l1_rd_busy", {31'h0, moc1}, 32'h0);
    @(posedge CLK); #1;
    check_eq("l1_rd_moc", {31'h0, moc1}, 32'h1);
    check_eq("l1_rd_dout", dout1, 32'h0BADCAFE);
    @(posedge CLK); #1;
    check_eq("l1_pulse_end", {31'h0, moc1}, 32'h0);
    check_eq("l1_dout_held", dout1, 32'h0BADCAFE);
    check_eq("l1_err", {31'h0, err1}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_ram_moc.md
Name: data_ram_moc

Overview:
- Byte-addressable data/instruction RAM with a MOV/MOC handshake.
- Sits directly downstream of controlUnit: consumes MOV, RW, typeData and MAR address, and receives write data from MDR.
- Returns DataOut to MDR/IR and MOC back to controlUnit.
- Models fixed access latency so controlUnit wait states are exercised.

Parameters:
- LATENCY, 2, clock cycles from accepted request to MOC assertion; legal range 1..15.
- ADDR_W, 8, address width; memory depth is 2^ADDR_W bytes.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous active-low reset.
- MOV  in  1  memory operation valid; held high by controlUnit until MOC is seen.
- RW  in  1  1 = read, 0 = write.
- typeData  in  2  00 byte, 01 halfword, 10 word, 11 word (alias).
- address  in  ADDR_W  byte address, big-endian.
- DataIn  in  32  write data, right-justified for byte/halfword.
- DataOut  out  32  read data, zero-extended.
- MOC  out  1  memory operation complete.

Behaviour:
- Reset (CLR=0, async): state IDLE, MOC=0, DataOut=0, latency counter 0. Memory array is not cleared.
- Reset mid-operation aborts the access; no write is committed.
- FSM IDLE: on MOV=1, capture RW, typeData, address and DataIn into request registers; load counter=LATENCY-1; go BUSY. Inputs are ignored after capture.
- FSM BUSY: decrement the counter each cycle. When it reaches 0, perform the access and go DONE on the next edge.
- Latency: MOC rises exactly LATENCY cycles after the edge that sampled MOV=1.
- FSM DONE: MOC=1 while in DONE. On MOV=0, go IDLE and MOC=0 on the next edge.
- MOV held high in DONE: MOC stays high with no re-trigger. A new access requires MOV low for at least one sampled edge.
- Reads: DataOut is registered at entry to DONE and held until the next read completes. Writes leave DataOut unchanged.
- Big-endian byte lanes: word at A occupies bytes A..A+3, with byte A = bits 31:24. Halfword at A occupies A..A+1.
- Byte read: DataOut = {24'b0, mem[A]}. Halfword read: DataOut = {16'b0, mem[A], mem[A+1]}.
- Writes store DataIn[7:0], DataIn[15:0] or DataIn[31:0] into the matching lanes only; other bytes are untouched.
- Alignment (macro off): low address bits are forced to 0 — bit 0 for halfword, bits 1:0 for word. The access therefore never wraps past 2^ADDR_W-1.
- MOV dropped during BUSY: the access still completes. FSM goes DONE then IDLE on the next edge, since MOV is already 0; MOC is a one-cycle pulse.

Optional Feature:
- Macro: MISALIGN_ERR_EN.
- Defined:
  - Adds output ERR (1 bit, reset 0).
  - A misaligned halfword or word request performs no write, and a read returns DataOut=32'h0.
  - ERR=1 exactly while MOC=1 for that access.
- Undefined: no ERR port; force-alignment as above.

Decomposition:
- Shared package ram_pkg holds:
  - typeData encodings (TD_BYTE, TD_HALF, TD_WORD);
  - FSM state encoding (S_IDLE, S_BUSY, S_DONE);
  - RW constants (RW_READ=1, RW_WRITE=0).
- One sub-module, ram_lane_ctl (combinational): from typeData and aligned address it produces 4 byte-enables and the read merge/zero-extend. It is reused by the CU bench memory model.

Test Plan:
- Word write/read: write addr 8'h10, word, DataIn=32'hDEADBEEF, then read word at 8'h10 -> DataOut=32'hDEADBEEF, MOC high exactly 2 cycles after the MOV sample each time.
- Byte lanes: after the word above, read byte at 8'h11 -> 32'h000000AD; write byte 8'h55 at 8'h12, read word at 8'h10 -> 32'hDEAD55EF.
- Halfword and alignment: read halfword at 8'h13 (macro off) -> aligned to 8'h12, DataOut=32'h000055EF. With MISALIGN_ERR_EN -> DataOut=0 and ERR=1 during MOC.
- Handshake hold: keep MOV high 5 cycles after MOC -> MOC stays 1 with a single access. MOV low -> MOC=0 next edge. MOV high again -> a new access with MOC after LATENCY.
- Reset mid-op: start a write of 32'h12345678 to 8'h20 and assert CLR=0 in BUSY -> MOC=0 and DataOut=0 immediately. Subsequent word read of 8'h20 returns the prior contents, not 32'h12345678.
- LATENCY=1 build: read request -> MOC asserted on the first edge after the MOV sample; MOV dropped in BUSY -> one-cycle MOC pulse.
